aes_uart_tx_sequencer: RTL and testbench
========================================

Name: aes_uart_tx_sequencer

Overview:
- Upstream feeder for the UART transmitter. Accepts one 128-bit AES result block over a valid/ready handshake.
- Emits the block as 16 bytes, MSB byte first. Each byte goes out as a one-cycle tx_start pulse with tx_data.
- Paces starts so every pulse lands while the transmitter is back in IDLE; the transmitter has no busy output, so pacing is purely by cycle count.
- Sits between the AES core output register and uart_transmitter.start/data_in.

Parameters:
- BYTE_CYCLES, 8700, exact spacing in clk cycles between consecutive tx_start pulses. Must be >= 8691 when driving the transmitter (10 bits x 869 cycles, plus 1). Legal minimum is 2 for standalone use.
- CNT_W, $clog2(BYTE_CYCLES), width of the pacing counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- blk_in  input  128  AES block; byte 0 = blk_in[127:120], byte 15 = blk_in[7:0]
- blk_valid  input  1  blk_in is valid
- blk_ready  output  1  sequencer can accept a block (high only in IDLE)
- tx_data  output  8  byte to transmitter data_in
- tx_start  output  1  one-cycle start pulse to transmitter start
- busy  output  1  high from the accept cycle +1 until the done cycle
- done  output  1  one-cycle pulse when the last byte's pacing window ends

Behaviour:
- Reset values: state IDLE; tx_start=0, tx_data=8'h00, busy=0, done=0; counters 0; shift register 0.
- rst has priority at any time, including mid-block. The next cycle is IDLE with tx_start=0. The partially sent block is discarded, not resumed.
- States:
  - IDLE: blk_ready=1. On blk_valid&&blk_ready (cycle T): load blk_in into a 128-bit shift register, clear byte index, go to START.
  - START: lasts exactly 1 cycle. tx_start=1, tx_data=shift[127:120]. Shift register moves left by 8. Byte index increments. Pacing counter clears. Go to WAIT.
  - WAIT: pacing counter counts 0..BYTE_CYCLES-2, then exits:
    - if bytes remain, go to START;
    - otherwise go to IDLE and assert done for that one cycle.
- Timing:
  - Byte k start pulse at cycle T+1+k*BYTE_CYCLES, for k = 0..15.
  - done at T+1+16*BYTE_CYCLES. blk_ready is high in that same cycle, so back-to-back blocks have no extra bubble.
- Output registers:
  - tx_start and done are registered outputs and never high for 2 consecutive cycles.
  - tx_data is registered and updates only in START. It holds its value in WAIT and IDLE.
- blk_in is sampled only at the accept cycle; later changes are ignored. blk_valid while not ready is ignored; the block is not captured.
- busy = (state != IDLE).
- Byte index is 5 bits and never wraps: the last index is 15, or 16 with the optional feature.

Optional Feature:
- Macro: AES_UART_TX_CHECKSUM_EN.
- Defined:
  - A running XOR of all 16 transmitted bytes is accumulated; it is cleared on accept.
  - After byte 15's WAIT, a 17th START sends the XOR checksum byte.
  - done moves to T+1+17*BYTE_CYCLES.
- Undefined:
  - Exactly 16 bytes are sent, with no checksum logic.

Test Plan:
- Reset, then BYTE_CYCLES=20 and blk_in=128'h000102030405060708090A0B0C0D0E0F accepted at T.
  -> tx_start pulses at T+1, T+21, ..., T+301 with tx_data 00,01,...,0F.
  -> done at T+321; busy high over T+1..T+320.
- blk_valid held high across two blocks (second block 128'hFF..FF).
  -> second accept in the done cycle; first FF start pulse 1 cycle after it.
  -> blk_ready low throughout sending.
- Change blk_in and pulse blk_valid during WAIT.
  -> transmitted bytes match the originally accepted block; no second accept until IDLE.
- Assert rst during byte 7's WAIT.
  -> next cycle: tx_start=0, busy=0, blk_ready=1, tx_data=00; no further pulses; a new block then starts from byte 0.
- Integrated with uart_transmitter at default BYTE_CYCLES=8700, block 128'h00112233445566778899AABBCCDDEEFF.
  -> serial_out decodes (LSB-first, 1 start bit, 1 stop bit) to 00,11,...,FF in order, with no dropped start pulse.
- With AES_UART_TX_CHECKSUM_EN and the first block.
  -> 17th byte = 8'h00 (XOR of 00..0F); done at T+1+17*BYTE_CYCLES.

Source files
------------

// File: rtl/aes_uart_tx_sequencer.sv
// Serialises one 128-bit AES block into 16 paced tx_start/tx_data bytes, MSB byte first.
// Optional macro AES_UART_TX_CHECKSUM_EN appends a 17th XOR checksum byte.
module aes_uart_tx_sequencer #(
    parameter int BYTE_CYCLES = 8700,
    parameter int CNT_W       = $clog2(BYTE_CYCLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] blk_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

`ifdef AES_UART_TX_CHECKSUM_EN
    localparam logic [4:0] NUM_BYTES = 5'd17;
`else
    localparam logic [4:0] NUM_BYTES = 5'd16;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES - 2);

    state_e           state_q, state_d;
    logic [127:0]     shift_q, shift_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             done_q, done_d;
    logic [7:0]       next_byte;
`ifdef AES_UART_TX_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    always_comb begin
        next_byte = shift_q[127:120];
`ifdef AES_UART_TX_CHECKSUM_EN
        // Once all 16 data bytes are out the shifter is empty; send the running XOR instead.
        if (idx_q == 5'd16) begin
            next_byte = csum_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
`ifdef AES_UART_TX_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // tx_start/tx_data are registered, so they are set on the edge that enters START.
        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    shift_d    = blk_in;
                    idx_d      = 5'd0;
                    tx_start_d = 1'b1;
                    tx_data_d  = blk_in[127:120];
                    state_d    = S_START;
`ifdef AES_UART_TX_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            S_START: begin
                shift_d = {shift_q[119:0], 8'h00};
                idx_d   = idx_q + 5'd1;
                cnt_d   = '0;
                state_d = S_WAIT;
`ifdef AES_UART_TX_CHECKSUM_EN
                if (idx_q < 5'd16) begin
                    csum_d = csum_q ^ tx_data_q;
                end
`endif
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == NUM_BYTES) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tx_start_d = 1'b1;
                        tx_data_d  = next_byte;
                        state_d    = S_START;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef AES_UART_TX_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
`ifdef AES_UART_TX_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign blk_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_uart_tx_sequencer.sv
// Bench for aes_uart_tx_sequencer: directed vector table, corner sequences and random traffic
// checked every cycle against a cycle-count reference model.
module tb_aes_uart_tx_sequencer;

    localparam int BC = 20;
`ifdef AES_UART_TX_CHECKSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif
    localparam int IDLE_C = NB * BC + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] blk_in;
    logic         blk_valid;
    logic         blk_ready;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         busy;
    logic         done;

    aes_uart_tx_sequencer #(.BYTE_CYCLES(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_in    (blk_in),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int k);
        logic [7:0] x;
        x = 8'h00;
        if (k < 16) return b[127-8*k -: 8];
        for (int i = 0; i < 16; i++) x ^= b[127-8*i -: 8];
        return x;
    endfunction

    function automatic bit is_start(input int c);
        return (c >= 1) && (c <= NB * BC) && ((c - 1) % BC == 0);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: cycles elapsed since the last accepted block.
    int           m_c;
    logic [127:0] m_blk;
    logic [7:0]   m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_c    <= IDLE_C;
            m_data <= 8'h00;
        end else if (m_c > NB * BC && blk_valid) begin
            m_c    <= 1;
            m_blk  <= blk_in;
            m_data <= blk_in[127:120];
        end else begin
            if (m_c < IDLE_C) m_c <= m_c + 1;
            if (is_start(m_c + 1)) m_data <= byte_of(m_blk, m_c / BC);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs{ready,busy,start,done,data}",
                  {blk_ready, busy, tx_start, done, tx_data},
                  {(m_c > NB * BC), (m_c <= NB * BC), is_start(m_c), (m_c == NB * BC + 1), m_data});
        end
    end

    logic [7:0] got[$];
    int         got_cyc[$];
    int         done_cyc[$];

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    function automatic int qsize(input int which);
        return (which == 0) ? got.size() : done_cyc.size();
    endfunction

    task automatic wait_for(input int which, input int n, input int limit, input string nm);
        for (int i = 0; i < limit; i++) begin
            if (qsize(which) >= n) break;
            @(negedge clk);
        end
        check(nm, (qsize(which) >= n), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NB * BC + 50; i++) begin
            @(negedge clk);
            if (blk_ready === 1'b1 && done === 1'b0 && tx_start === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_wait", ok, 1);
    endtask

    task automatic send(input logic [127:0] b, output int a);
        wait_idle();
        got.delete();
        got_cyc.delete();
        done_cyc.delete();
        blk_in    = b;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        a = cyc;
    endtask

    typedef struct {
        logic [127:0] blk;
        logic [7:0]   b0;
        logic [7:0]   b15;
        logic [7:0]   xsum;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int a;
        int n;
        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 8'h00, 8'h0F, 8'h00};
        vecs[1] = '{128'h00112233445566778899AABBCCDDEEFF, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{128'h80000000000000000000000000000001, 8'h80, 8'h01, 8'h81};
        vecs[3] = '{128'hDEADBEEF0123456789ABCDEFCAFEF00D, 8'hDE, 8'h0D, 8'hEB};

        rst       = 1'b1;
        blk_valid = 1'b0;
        blk_in    = '0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_state", {blk_ready, busy, tx_start, done, tx_data}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].blk, a);
            wait_for(1, 1, NB * BC + 50, "done_timeout");
            check("pulse_count", got.size(), NB);
            if (got.size() >= NB && done_cyc.size() >= 1) begin
                check("byte0", got[0], vecs[i].b0);
                check("byte15", got[15], vecs[i].b15);
`ifdef AES_UART_TX_CHECKSUM_EN
                check("checksum_byte", got[16], vecs[i].xsum);
`endif
                check("first_pulse_lat", got_cyc[0] - a, 0);
                check("last_pulse_lat", got_cyc[NB-1] - a, (NB - 1) * BC);
                check("done_lat", done_cyc[0] - a, NB * BC);
            end
        end

        // Back-to-back: valid held high, second block accepted in the done cycle.
        wait_idle();
        got.delete();
        got_cyc.delete();
        done_cyc.delete();
        blk_in    = vecs[0].blk;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_in = '1;
        wait_for(1, 1, NB * BC + 50, "b2b_done1_timeout");
        @(negedge clk);
        blk_valid = 1'b0;
        wait_for(1, 2, NB * BC + 50, "b2b_done2_timeout");
        check("b2b_pulse_count", got.size(), 2 * NB);
        if (got.size() >= NB + 1 && done_cyc.size() >= 1) begin
            check("b2b_last_of_first", got[NB-1], byte_of(vecs[0].blk, NB - 1));
            check("b2b_first_ff", got[NB], 8'hFF);
            check("b2b_no_bubble", got_cyc[NB] - done_cyc[0], 1);
        end

        // Input disturbance while sending must not affect the captured block.
        send(vecs[3].blk, a);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            blk_in    = {$urandom, $urandom, $urandom, $urandom};
            blk_valid = 1'($urandom_range(0, 1));
        end
        blk_valid = 1'b0;
        wait_for(1, 1, NB * BC + 50, "disturb_done_timeout");
        check("disturb_count", got.size(), NB);
        for (int k = 0; k < NB && k < got.size(); k++) begin
            check("disturb_byte", got[k], byte_of(vecs[3].blk, k));
        end

        // Reset during byte 7's pacing window.
        send(vecs[1].blk, a);
        wait_for(0, 8, 8 * BC + 20, "reset_pulse7_timeout");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midblock_reset", {blk_ready, busy, tx_start, done, tx_data}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        n = got.size();
        repeat (3 * BC) @(negedge clk);
        check("no_pulse_after_reset", got.size(), n);
        check("no_done_after_reset", done_cyc.size(), 0);
        send(vecs[2].blk, a);
        wait_for(1, 1, NB * BC + 50, "restart_done_timeout");
        check("restart_count", got.size(), NB);
        if (got.size() >= 1) check("restart_byte0", got[0], vecs[2].b0);

        // Random traffic, including occasional reset, checked by the reference model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            blk_valid = ($urandom_range(0, 7) == 0);
            blk_in    = {$urandom, $urandom, $urandom, $urandom};
            rst       = ($urandom_range(0, 1499) == 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        blk_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
